// File: rtl/mem_access_pkg.sv
// Shared constants and types for the load/store memory access unit.
package mem_access_pkg;

  // RISC-V funct3 size/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Access sequencer states
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    WRITE,
    RESP
  } mau_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic for a 4-lane word port: load extract/extend, store lane
// merge and illegal/misaligned request detection. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             we_i,
  input  logic [2:0]       funct3_i,
  input  logic [1:0]       addr_lo_i,
  input  logic [WIDTH-1:0] rd_word_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] load_data_o,
  output logic [WIDTH-1:0] merged_o,
  output logic             err_o
);

  localparam int LANES = 4;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_legal;
  logic        w_misaligned;

  // Pick the addressed byte and half out of the word read from RAM.
  always_comb begin
    w_byte = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    w_half = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
  end

  // Sign- or zero-extend the selected lanes according to funct3.
  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{(WIDTH-8){w_byte[7]}}, w_byte};
      F3_BU:   load_data_o = {{(WIDTH-8){1'b0}}, w_byte};
      F3_H:    load_data_o = {{(WIDTH-16){w_half[15]}}, w_half};
      F3_HU:   load_data_o = {{(WIDTH-16){1'b0}}, w_half};
      F3_W:    load_data_o = rd_word_i;
      default: load_data_o = '0;
    endcase
  end

  // Flag size codes not valid for the direction and addresses not aligned to the size.
  always_comb begin
    if (we_i) begin
      w_legal = funct3_i inside {F3_B, F3_H, F3_W};
    end else begin
      w_legal = funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    end
    w_misaligned = 1'b0;
    case (funct3_i[1:0])
      2'd1:    w_misaligned = addr_lo_i[0];
      2'd2:    w_misaligned = |addr_lo_i;
      default: w_misaligned = 1'b0;
    endcase
    err_o = !w_legal || w_misaligned;
  end

  // Store merge: each lane takes store data when it is covered, else keeps the read byte.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic       w_en;
    logic [7:0] w_src;

    // Decide whether this lane is written and which store-data byte feeds it.
    always_comb begin
      case (funct3_i[1:0])
        2'd0: begin
          w_en  = (addr_lo_i == 2'(gi));
          w_src = wdata_i[7:0];
        end
        2'd1: begin
          w_en  = (addr_lo_i[1] == 1'(gi / 2));
          w_src = wdata_i[(gi % 2) * 8 +: 8];
        end
        default: begin
          w_en  = 1'b1;
          w_src = wdata_i[gi * 8 +: 8];
        end
      endcase
    end

    assign merged_o[gi * 8 +: 8] = w_en ? w_src : rd_word_i[gi * 8 +: 8];
  end

  if (WIDTH > 32) begin : g_upper
    assign merged_o[WIDTH-1:32] = rd_word_i[WIDTH-1:32];
  end

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side load/store initiator for a word-wide RAM with combinational read
// and negedge write. Sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [WIDTH-1:0] req_addr_i,
  input  logic [WIDTH-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  output logic [WIDTH-1:0] rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_a_o,
  output logic [WIDTH-1:0] mem_wd_o,
  input  logic [WIDTH-1:0] mem_rd_i
);

  mau_state_t r_state;
  mau_state_t w_state_next;

  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_merged;
  logic [WIDTH-1:0] r_rdata;
  logic [2:0]       r_funct3;
  logic             r_we;
  logic             r_err;

  logic             w_idle;
  logic             w_accept;
  logic             w_sel_we;
  logic [2:0]       w_sel_funct3;
  logic [1:0]       w_sel_addr_lo;
  logic [WIDTH-1:0] w_sel_wdata;
  logic [WIDTH-1:0] w_load_data;
  logic [WIDTH-1:0] w_merged;
  logic             w_err;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = req_valid_i && w_idle;

  // In IDLE the lane logic checks the incoming request; afterwards it works on the latched one.
  always_comb begin
    w_sel_we      = w_idle ? req_we_i          : r_we;
    w_sel_funct3  = w_idle ? req_funct3_i      : r_funct3;
    w_sel_addr_lo = w_idle ? req_addr_i[1:0]   : r_addr[1:0];
    w_sel_wdata   = w_idle ? req_wdata_i       : r_wdata;
  end

  mem_lane_align #(
    .WIDTH(WIDTH)
  ) u_align (
    .we_i       (w_sel_we),
    .funct3_i   (w_sel_funct3),
    .addr_lo_i  (w_sel_addr_lo),
    .rd_word_i  (mem_rd_i),
    .wdata_i    (w_sel_wdata),
    .load_data_o(w_load_data),
    .merged_o   (w_merged),
    .err_o      (w_err)
  );

  // State register; reset aborts any access in flight, including a pending write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: route accepted requests by kind, then walk to a single response cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_next = RESP;
          end else if (!req_we_i) begin
            w_state_next = LOAD;
          end else if (req_funct3_i == F3_W) begin
            w_state_next = WRITE;
          end else begin
            w_state_next = RMW_RD;
          end
        end
      end
      LOAD:    w_state_next = RESP;
      RMW_RD:  w_state_next = WRITE;
      WRITE:   w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request latching, load result capture and store word assembly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_we     <= 1'b0;
      r_merged <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr   <= req_addr_i;
            r_wdata  <= req_wdata_i;
            r_funct3 <= req_funct3_i;
            r_we     <= req_we_i;
            r_merged <= req_wdata_i;
            r_rdata  <= '0;
            r_err    <= w_err;
          end
        end
        LOAD:   r_rdata  <= w_load_data;
        RMW_RD: r_merged <= w_merged;
        RESP: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the state register only, so they are stable across the write negedge.
  always_comb begin
    req_ready_o = w_idle;
    rsp_valid_o = (r_state == RESP);
    rsp_rdata_o = r_rdata;
    rsp_err_o   = r_err;
    mem_we_o    = (r_state == WRITE);
    mem_a_o     = '0;
    mem_wd_o    = '0;
    if (r_state inside {LOAD, RMW_RD, WRITE}) begin
      mem_a_o = {r_addr[WIDTH-1:2], 2'b00};
    end
    if (r_state == WRITE) begin
      mem_wd_o = r_merged;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word RAM model and a
// behavioural reference model of loads, stores, errors and latency.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] ram     [0:255];
  logic [31:0] ref_mem [0:255];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_funct3_i(req_funct3),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mem_we_o    (mem_we),
    .mem_a_o     (mem_a),
    .mem_wd_o    (mem_wd),
    .mem_rd_i    (mem_rd)
  );

  // RAM: combinational read, whole-word write on the falling edge
  assign mem_rd = ram[mem_a[9:2]];
  always @(negedge clk) begin
    if (mem_we) ram[mem_a[9:2]] <= mem_wd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // ---- reference model, written from the access rules ----
  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic legal;
    logic mis;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    mis = ((f3 % 4) == 1 && (addr % 2) != 0) || ((f3 % 4) == 2 && (addr % 4) != 0);
    return !legal || mis;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] addr);
    logic [31:0] b;
    logic [31:0] h;
    int unsigned off;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b ^ 32'h80) - 32'h80;
      3'd4:    return b;
      3'd1:    return (h ^ 32'h8000) - 32'h8000;
      3'd5:    return h;
      3'd2:    return word;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] mask;
    int unsigned off;
    off  = addr % 4;
    mask = (f3 == 3'd0) ? 32'hFF : (f3 == 3'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    mask = mask << (8 * off);
    return (word & ~mask) | ((wd << (8 * off)) & mask);
  endfunction

  // One request: drive, accept, watch the following cycles and compare with the model.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    logic [7:0]  idx;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_word;
    int          e_lat;
    int          e_wcnt;
    int          lat;
    int          wcnt;
    int          wcyc;
    logic [31:0] g_rdata;
    logic [31:0] g_wd;
    logic        g_err;
    logic        a_bad;

    idx     = addr[9:2];
    e_err   = model_err(we, f3, addr);
    e_rdata = (!we && !e_err) ? model_load(ref_mem[idx], f3, addr) : 32'h0;
    e_word  = model_store(ref_mem[idx], f3, addr, wd);
    if (e_err)                  e_lat = 1;
    else if (we && f3 != 3'd2)  e_lat = 3;
    else                        e_lat = 2;
    e_wcnt = (we && !e_err) ? 1 : 0;
    if (e_wcnt == 1) ref_mem[idx] = e_word;

    @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;

    lat = -1; wcnt = 0; wcyc = -1; a_bad = 1'b0;
    g_rdata = 'x; g_err = 1'bx; g_wd = 'x;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_we) begin
        wcnt++;
        wcyc = k;
        g_wd = mem_wd;
      end
      if (rsp_valid) begin
        lat     = k;
        g_rdata = rsp_rdata;
        g_err   = rsp_err;
        break;
      end
      if (mem_a !== {addr[31:2], 2'b00}) a_bad = 1'b1;
    end

    check("rsp_latency", 32'(lat), 32'(e_lat));
    check("rsp_rdata",   g_rdata, e_rdata);
    check("rsp_err",     {31'b0, g_err}, {31'b0, e_err});
    check("write_count", 32'(wcnt), 32'(e_wcnt));
    check("mem_addr",    {31'b0, a_bad}, 32'd0);
    if (e_wcnt == 1) begin
      check("write_cycle", 32'(wcyc), 32'(e_lat - 1));
      check("write_data",  g_wd, e_word);
    end
    $display("txn we=%0d f3=%0d addr=%h wd=%h -> lat=%0d rdata=%h err=%0d writes=%0d",
             we, f3, addr, wd, lat, g_rdata, g_err, wcnt);
  endtask

  // Hold one request valid for 12 cycles: accepts only in IDLE, spaced by the access latency.
  task automatic b2b(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input int spacing, input int exp_count);
    int accepts;
    int rsps;
    int prev;
    accepts = 0; rsps = 0; prev = -1;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = 32'h0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp_valid) rsps++;
      if (req_ready) begin
        if (prev >= 0) check("b2b_gap", 32'(c - prev), 32'(spacing));
        prev = c;
        accepts++;
      end
      if (c == 0) req_valid = 1'b1;
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(accepts), 32'(exp_count));
    check("b2b_rsps",    32'(rsps),    32'(exp_count));
    $display("b2b f3=%0d addr=%h -> accepts=%0d rsps=%0d", f3, addr, accepts, rsps);
    @(negedge clk);
  endtask

  initial begin
    logic        rsp_seen;
    logic        rw;
    logic [2:0]  rf3;
    logic [31:0] raddr;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[0]     = 32'h80F07F01;
    ref_mem[0] = 32'h80F07F01;

    // reset values
    #12;
    check("rst_ready",  {31'b0, req_ready}, 32'd1);
    check("rst_rvalid", {31'b0, rsp_valid}, 32'd0);
    check("rst_err",    {31'b0, rsp_err},   32'd0);
    check("rst_rdata",  rsp_rdata, 32'h0);
    check("rst_we",     {31'b0, mem_we},    32'd0);
    check("rst_a",      mem_a,  32'h0);
    check("rst_wd",     mem_wd, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;

    // directed loads
    txn(1'b0, 3'd2, 32'h10000, 32'h0);
    txn(1'b0, 3'd0, 32'h10003, 32'h0);
    txn(1'b0, 3'd4, 32'h10003, 32'h0);
    txn(1'b0, 3'd1, 32'h10002, 32'h0);
    txn(1'b0, 3'd5, 32'h10000, 32'h0);
    // read-modify-write stores and full word store
    txn(1'b1, 3'd0, 32'h10001, 32'h12345678);
    txn(1'b0, 3'd2, 32'h10000, 32'h0);
    check("sb_result", ref_mem[0], 32'h80F07801);
    txn(1'b1, 3'd1, 32'h10002, 32'hAAAABEEF);
    check("sh_result", ram[0], 32'hBEEF7801);
    txn(1'b1, 3'd2, 32'h10000, 32'hDEADBEEF);
    txn(1'b0, 3'd2, 32'h10000, 32'h0);
    // error requests
    txn(1'b0, 3'd2, 32'h10002, 32'h0);
    txn(1'b1, 3'd1, 32'h10001, 32'h5555AAAA);
    txn(1'b0, 3'd3, 32'h10000, 32'h0);
    check("err_mem_unchanged", ram[0], 32'hDEADBEEF);

    // reset during the WRITE cycle of an SB
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h10000; req_wdata = 32'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("rst_mid_we_before", {31'b0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_we",    {31'b0, mem_we},    32'd0);
    check("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mid_rsp",   {31'b0, rsp_valid}, 32'd0);
    check("rst_mid_a",     mem_a, 32'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    rsp_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    check("rst_mid_no_rsp", {31'b0, rsp_seen}, 32'd0);
    check("rst_mid_word",   ram[0], ref_mem[0]);
    $display("reset abort of SB at 10000 -> word=%h", ram[0]);
    txn(1'b0, 3'd2, 32'h10000, 32'h0);

    // held request valid
    b2b(1'b0, 3'd2, 32'h10000, 3, 4);
    b2b(1'b0, 3'd3, 32'h10000, 2, 6);

    // randomized requests
    for (int n = 0; n < 40; n++) begin
      rw    = 1'($urandom_range(0, 1));
      rf3   = 3'($urandom_range(0, 7));
      raddr = 32'h10000 + 32'($urandom_range(0, 63));
      txn(rw, rf3, raddr, $urandom);
    end

    // final memory image vs model
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      check("final_mem", ram[i], ref_mem[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- CPU-side initiator for the byte-addressed data RAM (32-bit word port, combinational read, full-word write on the negative clock edge when write-enable is high).
- Accepts load/store requests from the execute/memory stage through a valid/ready handshake and issues word-aligned RAM accesses.
- Loads LB/LH/LW/LBU/LHU extract the addressed lanes and sign- or zero-extend them.
- The RAM only writes whole words, so SB/SH are done as read-modify-write; SW is a single write.
- Returns a one-cycle response pulse carrying the data or an error.

Parameters:
- WIDTH, 32, address and data width; the byte-lane logic is fixed for 4 lanes.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- rst_i  input  1  asynchronous reset, active-high.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  unit can accept a request (high only in IDLE).
- req_we_i  input  1  1 = store, 0 = load.
- req_funct3_i  input  3  RISC-V funct3 size/sign code.
- req_addr_i  input  WIDTH  byte address.
- req_wdata_i  input  WIDTH  store data, right-justified.
- rsp_valid_o  output  1  one-cycle response pulse.
- rsp_rdata_o  output  WIDTH  load result; 0 for stores and errors.
- rsp_err_o  output  1  misaligned address or illegal funct3; valid with rsp_valid_o.
- mem_we_o  output  1  RAM write enable.
- mem_a_o  output  WIDTH  RAM byte address, always {addr[31:2],2'b00}.
- mem_wd_o  output  WIDTH  RAM write data.
- mem_rd_i  input  WIDTH  RAM combinational read data.

Behaviour:
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0, mem_we_o=0, mem_a_o=0, mem_wd_o=0. All latched request registers clear to 0.
- Handshake and latching:
  - A request is accepted on the posedge where req_valid_i && req_ready_o.
  - addr, we, funct3 and wdata are latched at that edge.
  - Request inputs are ignored outside IDLE.
- States:
  - IDLE, on accept:
    - error → RESP with err set;
    - load → LOAD;
    - SW → WRITE;
    - SB/SH → RMW_RD.
  - LOAD: drive mem_a_o; at the posedge, capture the extracted and extended mem_rd_i into rsp_rdata, then → RESP.
  - RMW_RD: drive mem_a_o; at the posedge, latch the merged word (mem_rd_i with the store lanes replaced), then → WRITE.
  - WRITE: mem_we_o=1 for exactly this cycle (RAM commits at its negedge), mem_wd_o = merged word (SW: wdata); → RESP.
  - RESP: rsp_valid_o=1 for one cycle; no backpressure; → IDLE.
- Latency, with accept at edge N:
  - load or SW: response in cycle N+2;
  - SB/SH: response in cycle N+3;
  - error: response in cycle N+1.
  - Back-to-back: the next accept is possible in the cycle after RESP.
- Errors (no RAM access, mem_we_o stays 0, rdata=0, err=1):
  - funct3 ∉ {0,1,2,4,5} for loads or ∉ {0,1,2} for stores;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0.
- Load extraction:
  - LB/LBU use the byte lane given by addr[1:0];
  - LH/LHU use the half selected by addr[1];
  - LB/LH sign-extend, LBU/LHU zero-extend.
- Store merge:
  - SB replaces byte lane addr[1:0] with wdata[7:0];
  - SH replaces half addr[1] with wdata[15:0];
  - other bytes are preserved from the RMW_RD read.
- mem_we_o is decoded only from the state register, so it is stable from posedge to the following negedge.
- mem_a_o holds the aligned address throughout LOAD/RMW_RD/WRITE and is 0 in IDLE.
- Reset mid-operation: everything returns to reset values immediately. If asserted during WRITE before the negedge, the write is suppressed; no response is emitted for the aborted request.

Decomposition:
- Package mem_access_pkg:
  - funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5);
  - state enum typedef mau_state_t {IDLE, LOAD, RMW_RD, WRITE, RESP}.
- One combinational sub-module, mem_lane_align:
  - load extract/extend;
  - store lane merge;
  - misalign/illegal detection.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Bench setup: connect the RAM model; preload word 0x10000 = 0x80F07F01.
- LW 0x10000 → rsp_valid_o at N+2, rdata 0x80F07F01, err=0; mem_we_o never high.
- Loads, with one response each:
  - LB 0x10003 → 0xFFFFFF80;
  - LBU 0x10003 → 0x00000080;
  - LH 0x10002 → 0xFFFF80F0;
  - LHU 0x10000 → 0x00007F01.
- SB 0x10001, wdata 0x12345678:
  - RMW_RD at N+1;
  - mem_we_o high only in N+2 with mem_wd_o 0x80F07801;
  - rsp at N+3, rdata 0;
  - a following LW returns 0x80F07801.
- SH 0x10002, wdata 0xAAAABEEF → write word 0xBEEF7801. Then SW 0x10000, wdata 0xDEADBEEF → mem_we_o in N+1, rsp at N+2, a following LW returns 0xDEADBEEF.
- Error requests each give rsp at N+1 with err=1, rdata 0, no mem_we_o, memory unchanged:
  - LW 0x10002;
  - SH 0x10001;
  - load funct3=3.
- Reset mid-operation:
  - Assert rst_i mid-cycle during WRITE of an SB to 0x10000 → mem_we_o drops immediately, word unchanged, req_ready_o=1 at once, no rsp_valid_o.
  - Hold req_valid_i high continuously → accepts occur only in IDLE, spaced by the per-type latency.
